regfile_scoreboard: RTL

Parametrised successor to the single-cycle integer register file, for the pipelined core. It provides two combinational read ports and one clocked write port, with x0 hardwired to zero and optional write-to-read bypass. A per-register pending scoreboard lets issue logic detect RAW hazards. A post-reset clear sequencer zeroes the array without an asynchronous reset on the storage.

---
 rtl/regfile_scoreboard.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with two combinational read ports, one write port, x0 tied to zero,
// a per-register pending scoreboard and a post-reset clear sequencer for the storage array.
module regfile_scoreboard #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [XLEN-1:0]   i_wd,
  input  logic              i_iss_valid,
  input  logic [ADDR_W-1:0] i_iss_rd,
  output logic              o_init_done
);

  localparam int unsigned       NREGS  = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   LAST   = (ADDR_W + 1)'(NREGS - 1);
  localparam logic [ADDR_W:0]   ONE    = (ADDR_W + 1)'(1);
  localparam logic              BYP_EN = (BYPASS != 0);
  localparam logic [NREGS-1:0]  BIT0   = {{(NREGS - 1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W:0]     w_cnt_nxt;
  logic [XLEN-1:0]     r_mem [NREGS];
  logic [NREGS-1:0]    r_pending;
  logic [NREGS-1:0]    w_pending_nxt;
  logic [NREGS-1:0]    w_clr_mask;
  logic [NREGS-1:0]    w_set_mask;
  logic                w_run;
  logic                w_wr_ok;
  logic                w_iss_ok;
  logic                w_rs1_hit;
  logic                w_rs2_hit;
  logic                w_rs1_zero;
  logic                w_rs2_zero;

  assign w_run    = (r_state == ST_RUN);
  assign w_wr_ok  = w_run && i_we && (i_wa != {ADDR_W{1'b0}});
  assign w_iss_ok = w_run && i_iss_valid && (i_iss_rd != {ADDR_W{1'b0}});

  // State and clear-counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_INIT;
      r_cnt   <= ONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: walk the clear counter up to the last register, then stay in RUN
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        w_cnt_nxt = r_cnt + ONE;
        if (r_cnt == LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = ONE;
      end
    endcase
  end

  // Storage array: no reset; zeroed by the clear sequencer, x0 never written
  always_ff @(posedge i_clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_cnt[ADDR_W-1:0]] <= {XLEN{1'b0}};
    end else if (w_wr_ok) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  // Issue sets after writeback clears, so a same-edge issue (younger) leaves the bit set
  assign w_clr_mask    = w_wr_ok  ? (BIT0 << i_wa)     : {NREGS{1'b0}};
  assign w_set_mask    = w_iss_ok ? (BIT0 << i_iss_rd) : {NREGS{1'b0}};
  assign w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;

  // Pending scoreboard register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= {NREGS{1'b0}};
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign w_rs1_zero = (i_rs1_addr == {ADDR_W{1'b0}});
  assign w_rs2_zero = (i_rs2_addr == {ADDR_W{1'b0}});
  assign w_rs1_hit  = BYP_EN && i_we && (i_wa == i_rs1_addr);
  assign w_rs2_hit  = BYP_EN && i_we && (i_wa == i_rs2_addr);

  assign o_rs1_data = (!w_run || w_rs1_zero) ? {XLEN{1'b0}} :
                      (w_rs1_hit ? i_wd : r_mem[i_rs1_addr]);
  assign o_rs2_data = (!w_run || w_rs2_zero) ? {XLEN{1'b0}} :
                      (w_rs2_hit ? i_wd : r_mem[i_rs2_addr]);
  assign o_rs1_busy = (!w_run || w_rs1_zero || w_rs1_hit) ? 1'b0 : r_pending[i_rs1_addr];
  assign o_rs2_busy = (!w_run || w_rs2_zero || w_rs2_hit) ? 1'b0 : r_pending[i_rs2_addr];

  assign o_init_done = w_run;

endmodule
